// File: rtl/rv32i_dmem_ctrl_pkg.sv
// Shared types for the RV32i data-memory controller.
// FSM encoding and default ACCESS timeout.
package RV32i_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_t;

  localparam int DMEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rv32i_dmem_ctrl.sv
// Data-memory controller: one core load/store at a time on a
// variable-latency word-SRAM bus, with range and timeout faults.
module rv32i_dmem_ctrl
  import RV32i_pkg::*;
#(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] BASE    = 32'h0001_0000,
  parameter int          TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       dmem_add_i,
  input  logic [31:0]       dmem_di_i,
  input  logic              dmem_we_i,
  input  logic              dmem_re_i,
  input  logic [3:0]        dmem_ble_i,
  output logic [31:0]       dmem_do_o,
  output logic              dmem_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_add_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o,
  output logic [31:0]       err_add_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HI = ADDR_W + 2;

  dmem_state_t   state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   cap_add;

  logic          req;
  logic          in_range;
  logic          last;
  logic          go_acc;
  logic          go_resp;
  logic          resp_err;
  logic [31:0]   resp_data;

  assign req      = dmem_we_i | dmem_re_i;
  assign in_range = dmem_add_i[31:HI] == BASE[31:HI];
  assign last     = cnt == CW'(TIMEOUT - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    go_acc    = 1'b0;
    go_resp   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (!in_range) begin
            state_n  = RESP;
            go_resp  = 1'b1;
            resp_err = 1'b1;
          end else if (dmem_we_i && dmem_ble_i == 4'b0000) begin
            state_n = RESP;
            go_resp = 1'b1;
          end else begin
            state_n = ACCESS;
            go_acc  = 1'b1;
          end
        end
      end
      ACCESS: begin
        // An ack on the final counted cycle still wins over timeout.
        if (mem_ack_i) begin
          state_n   = RESP;
          go_resp   = 1'b1;
          resp_data = mem_we_o ? 32'h0 : mem_rdata_i;
        end else if (last) begin
          state_n  = RESP;
          go_resp  = 1'b1;
          resp_err = 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmem_do_o    <= '0;
      dmem_valid_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_add_o    <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= '0;
      err_o        <= 1'b0;
      err_add_o    <= '0;
      cap_add      <= '0;
      cnt          <= '0;
    end else begin
      dmem_valid_o <= go_resp;
      err_o        <= go_resp & resp_err;
      mem_req_o    <= state_n == ACCESS;
      if (state == IDLE && req) begin
        mem_we_o    <= dmem_we_i;
        mem_add_o   <= dmem_add_i[HI-1:2];
        mem_wdata_o <= dmem_di_i;
        mem_be_o    <= dmem_ble_i;
        cap_add     <= dmem_add_i;
      end
      if (go_resp) begin
        dmem_do_o <= resp_data;
        // Range faults are decided in IDLE, before the capture lands.
        if (resp_err)
          err_add_o <= (state == IDLE) ? dmem_add_i : cap_add;
      end
      if (go_acc)
        cnt <= '0;
      else if (state == ACCESS)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Randomized bench for rv32i_dmem_ctrl against a transaction-level
// model of request/ack timing, data and fault reporting.
module tb_rv32i_dmem_ctrl;

  localparam int          ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam int          TO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       dmem_add;
  logic [31:0]       dmem_di;
  logic              dmem_we;
  logic              dmem_re;
  logic [3:0]        dmem_ble;
  logic [31:0]       dmem_do;
  logic              dmem_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_add;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              err;
  logic [31:0]       err_add;

  rv32i_dmem_ctrl #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .TIMEOUT(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dmem_add_i  (dmem_add),
    .dmem_di_i   (dmem_di),
    .dmem_we_i   (dmem_we),
    .dmem_re_i   (dmem_re),
    .dmem_ble_i  (dmem_ble),
    .dmem_do_o   (dmem_do),
    .dmem_valid_o(dmem_valid),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_add_o   (mem_add),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .err_o       (err),
    .err_add_o   (err_add)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // model of the transaction in flight
  logic        chk_en = 1'b0;
  int          t0 = -100;
  int          nreq = 0;
  int          tv = -1;
  logic [31:0] e_add, e_wdata, e_do, m_err_add;
  logic        e_we, e_err;
  logic [3:0]  e_be;

  // observations for literal checks
  logic [31:0] seen_do;
  logic        seen_err;
  int          seen_lat;
  int          req_cnt, req_eps, vcnt;
  logic        prev_req = 1'b0;
  logic [31:0] last_madd;
  logic        last_mwe;
  logic [3:0]  last_mbe;
  logic        er;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      er = cyc > t0 && cyc <= t0 + nreq;
      chk("mem_req", {31'h0, mem_req}, {31'h0, er});
      if (er) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, e_we});
        chk("mem_add", 32'(mem_add), 32'(e_add[ADDR_W+1:2]));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_be", {28'h0, mem_be}, {28'h0, e_be});
      end
      chk("valid", {31'h0, dmem_valid}, {31'h0, cyc == tv});
      chk("err", {31'h0, err}, {31'h0, (cyc == tv) && e_err});
      if (cyc == tv) begin
        chk("dmem_do", dmem_do, e_do);
        if (e_err) m_err_add = e_add;
      end
      chk("err_add", err_add, m_err_add);
      if (mem_req) begin
        req_cnt++;
        last_madd = 32'(mem_add);
        last_mwe  = mem_we;
        last_mbe  = mem_be;
      end
      if (mem_req && !prev_req) req_eps++;
      prev_req = mem_req;
      if (dmem_valid) begin
        vcnt++;
        seen_do  = dmem_do;
        seen_err = err;
        seen_lat = cyc - t0;
      end
    end
  end

  // Called at the negedge of an IDLE cycle; returns at the next IDLE.
  task automatic txn(input logic [31:0] a, input logic [31:0] di,
                     input logic we, input logic re,
                     input logic [3:0] ble, input int k,
                     input logic [31:0] rd);
    logic oor, skip;
    oor  = a[31:ADDR_W+2] != BASE[31:ADDR_W+2];
    skip = we && ble == 4'b0000;
    t0 = cyc;
    e_we = we;
    e_add = a;
    e_wdata = di;
    e_be = ble;
    nreq = (oor || skip) ? 0 : ((k <= TO) ? k : TO);
    tv = t0 + nreq + 1;
    e_err = oor || (!skip && k > TO);
    e_do = (!oor && !we && k <= TO) ? rd : 32'h0;
    seen_do = 32'hFFFF_FFFF;
    seen_err = 1'bx;
    seen_lat = -1;
    dmem_add = a;
    dmem_di = di;
    dmem_we = we;
    dmem_re = re;
    dmem_ble = ble;
    mem_ack = 1'($urandom % 2);
    mem_rdata = $urandom;
    while (cyc < tv) begin
      @(negedge clk);
      if (nreq > 0 && k <= TO && cyc == t0 + k) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_ack = (cyc > t0 + nreq) ? 1'($urandom % 2) : 1'b0;
        mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    dmem_we = 1'b0;
    dmem_re = 1'b0;
    repeat (n) begin
      dmem_add = $urandom;
      mem_ack = 1'($urandom % 2);
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  function automatic logic [31:0] rand_in();
    return {BASE[31:ADDR_W+2], 14'($urandom)};
  endfunction

  initial begin
    logic [31:0] a;
    logic        w, r;
    int          k;
    rst = 1'b1;
    dmem_add = '0;
    dmem_di = '0;
    dmem_we = 1'b0;
    dmem_re = 1'b0;
    dmem_ble = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    m_err_add = '0;
    #1;
    chk("rst_valid", {31'h0, dmem_valid}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_do", dmem_do, 32'h0);
    chk("rst_err_add", err_add, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // directed: load with ack at cycle 3
    txn(32'h0001_0040, 32'h0, 1'b0, 1'b1, 4'hF, 3, 32'hDEAD_BEEF);
    chk("t1_add", last_madd, 32'h010);
    chk("t1_lat", 32'(seen_lat), 32'd4);
    chk("t1_do", seen_do, 32'hDEAD_BEEF);
    chk("t1_err", {31'h0, seen_err}, 32'h0);

    // directed: store, immediate ack
    txn(32'h0001_0004, 32'h1234_5678, 1'b1, 1'b0, 4'b0011, 1, 32'hAAAA_5555);
    chk("t2_we", {31'h0, last_mwe}, 32'h1);
    chk("t2_be", {28'h0, last_mbe}, 32'h3);
    chk("t2_lat", 32'(seen_lat), 32'd2);
    chk("t2_do", seen_do, 32'h0);

    // directed: out-of-range load
    req_cnt = 0;
    txn(32'h0002_0000, 32'h0, 1'b0, 1'b1, 4'hF, 2, 32'h1);
    chk("t3_req", 32'(req_cnt), 32'd0);
    chk("t3_lat", 32'(seen_lat), 32'd1);
    chk("t3_err", {31'h0, seen_err}, 32'h1);
    chk("t3_err_add", err_add, 32'h0002_0000);
    idle(2);

    // directed: no ack -> timeout
    req_cnt = 0;
    txn(32'h0001_0100, 32'h0, 1'b0, 1'b1, 4'hF, 999, 32'h5);
    chk("t4_req", 32'(req_cnt), 32'd16);
    chk("t4_lat", 32'(seen_lat), 32'd17);
    chk("t4_do", seen_do, 32'h0);
    chk("t4_err", {31'h0, seen_err}, 32'h1);

    // directed: two back-to-back loads, request held through RESP
    req_eps = 0;
    vcnt = 0;
    txn(32'h0001_0200, 32'h0, 1'b0, 1'b1, 4'hF, 2, 32'h1111_2222);
    txn(32'h0001_0200, 32'h0, 1'b0, 1'b1, 4'hF, 2, 32'h3333_4444);
    idle(1);
    chk("t5_eps", 32'(req_eps), 32'd2);
    chk("t5_valids", 32'(vcnt), 32'd2);

    // directed: reset mid-ACCESS
    chk_en = 1'b0;
    dmem_add = 32'h0001_0300;
    dmem_we = 1'b0;
    dmem_re = 1'b1;
    dmem_ble = 4'hF;
    repeat (3) @(negedge clk);
    chk("t6_pre_req", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req", {31'h0, mem_req}, 32'h0);
    chk("t6_add", 32'(mem_add), 32'h0);
    chk("t6_err_add", err_add, 32'h0);
    chk("t6_valid", {31'h0, dmem_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dmem_re = 1'b0;
    t0 = -100;
    nreq = 0;
    tv = -1;
    m_err_add = '0;
    prev_req = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    txn(32'h0001_0300, 32'h0, 1'b0, 1'b1, 4'hF, 4, 32'hCAFE_F00D);
    chk("t6_do", seen_do, 32'hCAFE_F00D);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      a = rand_in();
      if ($urandom % 6 == 0)
        a = a ^ (32'h1 << $urandom_range(31, ADDR_W + 2));
      w = 1'($urandom % 2);
      r = w ? 1'($urandom % 2) : 1'b1;
      case ($urandom % 8)
        0:       k = $urandom_range(TO + 1, TO + 4);
        1:       k = TO;
        default: k = $urandom_range(1, 6);
      endcase
      txn(a, $urandom, w, r,
          ($urandom % 5 == 0) ? 4'h0 : 4'($urandom), k, $urandom);
      if ($urandom % 3 == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
